// File: rtl/uart_rx_fifo_hs.sv
// Receiver-side req/ack handshake feeding a synchronous byte FIFO with a registered read port.
// A byte that arrives while the FIFO is full is dropped and the sticky overflow flag is raised.
module uart_rx_fifo_hs #(
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rec_req,
  output logic              uart_rec_ack,
  input  logic [7:0]        uart_data_in,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr
);

  // Handshake: 4-phase. req high means uart_data_in is valid and stable; ack rises once
  // the byte has been taken (written or dropped) and falls only after req has been seen low.
  typedef enum logic {IDLE = 1'b0, WAIT_LOW = 1'b1} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic                req_s1_q, req_s2_q;
  logic [7:0]          mem_q [2**ADDR_W];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  logic                empty_q, full_q, ovf_q, ovf_d;
  logic [7:0]          rd_data_q;
  logic                rd_valid_q;
  logic                wr_att, wr_ok, wr_drop, rd_ok;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      req_s1_q <= uart_rec_req;
      req_s2_q <= req_s1_q;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_att  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s2_q) begin
          wr_att  = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
  always_comb begin
    rd_ok   = rd_en & ~empty_q;
    wr_ok   = wr_att & (~full_q | rd_ok);
    wr_drop = wr_att & ~wr_ok;
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (wr_drop)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= uart_data_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      rd_valid_q <= rd_ok;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == FULL_LVL);
      ovf_q      <= ovf_d;
    end
  end

  assign uart_rec_ack = (state_q == WAIT_LOW);
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign level        = level_q;
  assign overflow     = ovf_q;

endmodule
